// File: rtl/scroll_lane_bank.sv
// scroll_lane_bank: NUM_OBJ independent sprites scrolling left once per frame.
// Each lane owns its X/Y/sub-pixel accumulator. The bank owns the shared
// Galois LFSR (respawn Y source) and the saturating respawn counter.

// scroll_lane: one sprite. Advances by a sub-pixel step and respawns at the
// right edge with a pseudo-random Y once it is fully off the left edge.
module scroll_lane #(
  parameter int POS_W       = 10,
  parameter int FRAC_W      = 2,
  parameter int SPEED_W     = 6,
  parameter int X_MAX       = 639,
  parameter int X_START     = 640,
  parameter int SPACING     = 160,
  parameter int OBJ_SIZE    = 100,
  parameter int Y_MIN       = 250,
  parameter int Y_SPAN_LOG2 = 7,
  parameter int K           = 0
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic                   enable,
  input  logic                   restart,
  input  logic                   parallax,
  input  logic [SPEED_W-1:0]     speed,
  input  logic [Y_SPAN_LOG2-1:0] lfsr_lo,
  output logic [POS_W-1:0]       x,
  output logic [POS_W-1:0]       y,
  output logic                   vis,
  output logic                   wrap,
  output logic                   wrap_nxt
);
  // X is kept two bits wider than the output so the start layout (which
  // can reach past 1023) and the overshoot past the left edge never wrap.
  localparam int XW = POS_W + 2;
  localparam int STEP_W = SPEED_W + 1 - FRAC_W;
  localparam logic signed [XW-1:0] X_INIT    = XW'(X_START + K * SPACING);
  localparam logic signed [XW-1:0] X_RESPAWN = XW'(X_MAX + 1);
  localparam logic signed [XW-1:0] SIZE_S    = XW'(OBJ_SIZE);
  localparam logic signed [XW-1:0] XMAX_S    = XW'(X_MAX);
  localparam logic signed [XW-1:0] ZERO_S    = '0;
  // Per-lane decorrelation mask so simultaneous respawns draw distinct Y.
  localparam logic [15:0]          MASK      = 16'(K * 16'h9E37);

  logic signed [XW-1:0]    x_int, x_next;
  logic [FRAC_W-1:0]       acc;
  logic [SPEED_W-1:0]      s_k;
  logic [SPEED_W:0]        sum;
  logic [STEP_W-1:0]       step;
  logic                    exit_now;
  logic [Y_SPAN_LOG2-1:0]  r_lo;
  logic [POS_W-1:0]        y_new;

  // Step computation, exit test and respawn Y.
  always_comb begin
    s_k      = parallax ? (speed >> K) : speed;
    sum      = {1'b0, s_k} + (SPEED_W + 1)'(acc);
    step     = sum[SPEED_W:FRAC_W];
    x_next   = x_int - $signed(XW'(step));
    exit_now = (x_next + SIZE_S) <= ZERO_S;
    wrap_nxt = enable && !restart && exit_now;
    r_lo     = lfsr_lo ^ MASK[Y_SPAN_LOG2-1:0];
    y_new    = POS_W'(Y_MIN) + POS_W'(r_lo);
  end

  // Lane state: reset/restart reload the start layout, else advance.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_int <= X_INIT;
      y     <= POS_W'(Y_MIN);
      acc   <= '0;
      wrap  <= 1'b0;
    end else if (restart) begin
      x_int <= X_INIT;
      y     <= POS_W'(Y_MIN);
      acc   <= '0;
      wrap  <= 1'b0;
    end else if (enable) begin
      wrap <= exit_now;
      if (exit_now) begin
        x_int <= X_RESPAWN;
        y     <= y_new;
        acc   <= '0;
      end else begin
        x_int <= x_next;
        acc   <= sum[FRAC_W-1:0];
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign x   = x_int[POS_W-1:0];
  assign vis = ((x_int + SIZE_S) > ZERO_S) && (x_int <= XMAX_S);
endmodule

module scroll_lane_bank #(
  parameter int          NUM_OBJ     = 4,
  parameter int          POS_W       = 10,
  parameter int          FRAC_W      = 2,
  parameter int          SPEED_W     = 6,
  parameter int          X_MAX       = 639,
  parameter int          X_START     = 640,
  parameter int          SPACING     = 160,
  parameter int          OBJ_SIZE    = 100,
  parameter int          Y_MIN       = 250,
  parameter int          Y_SPAN_LOG2 = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       frame_clk,
  input  logic                       Reset_n,
  input  logic                       enable,
  input  logic                       restart,
  input  logic                       parallax,
  input  logic [SPEED_W-1:0]         speed,
  output logic [NUM_OBJ*POS_W-1:0]   obj_x,
  output logic [NUM_OBJ*POS_W-1:0]   obj_y,
  output logic [NUM_OBJ-1:0]         obj_vis,
  output logic [POS_W-1:0]           obj_size,
  output logic [NUM_OBJ-1:0]         wrap_pulse,
  output logic [15:0]                wrap_count
);
  localparam int CW = $clog2(NUM_OBJ + 1);

  logic [NUM_OBJ-1:0][POS_W-1:0] lane_x, lane_y;
  logic [NUM_OBJ-1:0]            wrap_nxt;
  logic [15:0]                   lfsr, lfsr_next;
  logic [CW-1:0]                 wrap_cnt;
  logic [16:0]                   count_sum;

  for (genvar k = 0; k < NUM_OBJ; k++) begin : g_lane
    scroll_lane #(
      .POS_W(POS_W), .FRAC_W(FRAC_W), .SPEED_W(SPEED_W), .X_MAX(X_MAX),
      .X_START(X_START), .SPACING(SPACING), .OBJ_SIZE(OBJ_SIZE),
      .Y_MIN(Y_MIN), .Y_SPAN_LOG2(Y_SPAN_LOG2), .K(k)
    ) u_lane (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .enable    (enable),
      .restart   (restart),
      .parallax  (parallax),
      .speed     (speed),
      .lfsr_lo   (lfsr[Y_SPAN_LOG2-1:0]),
      .x         (lane_x[k]),
      .y         (lane_y[k]),
      .vis       (obj_vis[k]),
      .wrap      (wrap_pulse[k]),
      .wrap_nxt  (wrap_nxt[k])
    );
  end

  // Galois LFSR step (x^16+x^14+x^13+x^11) and respawn popcount.
  always_comb begin
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    wrap_cnt  = '0;
    for (int i = 0; i < NUM_OBJ; i++) wrap_cnt = wrap_cnt + CW'(wrap_nxt[i]);
    count_sum = {1'b0, wrap_count} + 17'(wrap_cnt);
  end

  // Shared state: LFSR steps every enabled frame; restart leaves both alone.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr       <= LFSR_SEED;
      wrap_count <= '0;
    end else if (!restart && enable) begin
      lfsr       <= lfsr_next;
      wrap_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end

  assign obj_x    = lane_x;
  assign obj_y    = lane_y;
  assign obj_size = POS_W'(OBJ_SIZE);
endmodule
